// File: rtl/serial_link_pkg.sv
// Shared definitions for the serial link: line states and the idle line level.
// Used by the transmitter now and by the receiver later.
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_tx_if.sv
// Parallel-side handshake and serial-line outputs of the frame transmitter.
interface serial_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] DIN;
  logic              VALID;
  logic              READY;
  logic              TXD;
  logic              BUSY;

  modport master (output DIN, output VALID, input READY, input TXD, input BUSY);
  modport slave  (input DIN, input VALID, output READY, output TXD, output BUSY);

endinterface

// File: rtl/serial_tx_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, ticks on the last
// count and reloads; held at zero while disabled.
module bit_timer
  import serial_link_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic CLK,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  localparam int CW = cnt_w(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // NOTE: every signal written in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    cnt_d = cnt_q;
    TICK  = EN && (cnt_q == LAST);
    if (!EN || TICK) cnt_d = '0;
    else             cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/serial_tx.sv
// Frame transmitter: start bit, DATA_W data bits LSB-first, optional even
// parity, stop bit. All outputs are registered from the next-state values.
module serial_tx
  import serial_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  serial_tx_if.slave  bus
);

  localparam int BW = cnt_w(DATA_W);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              parity_q, parity_d;
  logic              txd_q, txd_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              tick;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .CLK   (CLK),
    .RESET (RESET),
    .EN    (state_q != IDLE),
    .TICK  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;

    case (state_q)
      IDLE: begin
        if (bus.VALID && ready_q) begin
          state_d   = START;
          shreg_d   = bus.DIN;
          parity_d  = ^bus.DIN;
          bit_cnt_d = '0;
        end
      end
      START:  if (tick) state_d = DATA;
      DATA: begin
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      PARITY: if (tick) state_d = STOP;
      STOP:   if (tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are derived from the state being entered so they line up with it.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shreg_d[0];
      PARITY:  txd_d = parity_q;
      default: txd_d = IDLE_LEVEL;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      txd_q     <= IDLE_LEVEL;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      parity_q  <= parity_d;
      txd_q     <= txd_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.TXD   = txd_q;
  assign bus.READY = ready_q;
  assign bus.BUSY  = busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: two instances (default framing, and fast
// no-parity framing) checked against a queue of expected line bits.
module tb_serial_tx;

  logic CLK;
  logic RESET;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   t0, t1;
  logic q_a[$];
  logic q_b[$];

  serial_tx_if #(.DATA_W(8)) bus_a ();
  serial_tx_if #(.DATA_W(8)) bus_b ();

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut_a (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_a)
  );

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut_b (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic txd_of(input int sel);
    return (sel == 0) ? bus_a.TXD : bus_b.TXD;
  endfunction

  function automatic logic ready_of(input int sel);
    return (sel == 0) ? bus_a.READY : bus_b.READY;
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? bus_a.BUSY : bus_b.BUSY;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_bit(input int sel, input logic b);
    if (sel == 0) q_a.push_back(b);
    else          q_b.push_back(b);
  endtask

  // Reference frame: start, data LSB-first, even parity if enabled, stop.
  task automatic push_frame(input int sel, input logic [7:0] data, input bit par_en);
    push_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) push_bit(sel, data[i]);
    if (par_en) push_bit(sel, ^data);
    push_bit(sel, 1'b1);
  endtask

  task automatic check_idle(input int sel, input string tag);
    check({tag, " txd"},   {31'd0, txd_of(sel)},   32'd1);
    check({tag, " ready"}, {31'd0, ready_of(sel)}, 32'd1);
    check({tag, " busy"},  {31'd0, busy_of(sel)},  32'd0);
  endtask

  // Called at the first falling edge after accept; drains the scoreboard one
  // cycle at a time, optionally pulsing VALID (and changing DIN) on cycle pulse_at.
  task automatic check_frame(input int sel, input int cpb, input string tag, input int pulse_at);
    int   k = 0;
    logic b;
    while (((sel == 0) ? q_a.size() : q_b.size()) != 0) begin
      if (sel == 0) b = q_a.pop_front();
      else          b = q_b.pop_front();
      for (int c = 0; c < cpb; c++) begin
        check({tag, " txd"},   {31'd0, txd_of(sel)},   {31'd0, b});
        check({tag, " ready"}, {31'd0, ready_of(sel)}, 32'd0);
        check({tag, " busy"},  {31'd0, busy_of(sel)},  32'd1);
        if (sel == 0 && pulse_at >= 0) begin
          bus_a.VALID = (k == pulse_at);
          if (k == pulse_at) bus_a.DIN = ~bus_a.DIN;
        end
        k++;
        @(negedge CLK);
      end
    end
    if (sel == 0 && pulse_at >= 0) bus_a.VALID = 1'b0;
    check_idle(sel, {tag, " end"});
  endtask

  initial begin
    RESET       = 1'b1;
    bus_a.DIN   = '0;
    bus_a.VALID = 1'b0;
    bus_b.DIN   = '0;
    bus_b.VALID = 1'b0;

    repeat (3) @(negedge CLK);
    check_idle(0, "reset_a");
    check_idle(1, "reset_b");
    RESET = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check_idle(0, "idle_a");
    end

    // Single frame 8'hA5 with one-cycle VALID.
    bus_a.DIN   = 8'hA5;
    bus_a.VALID = 1'b1;
    push_frame(0, 8'hA5, 1'b1);
    @(negedge CLK);
    bus_a.VALID = 1'b0;
    check_frame(0, 4, "a5", -1);

    // Back-to-back 8'hFF then 8'h00 with VALID held high.
    bus_a.DIN   = 8'hFF;
    bus_a.VALID = 1'b1;
    push_frame(0, 8'hFF, 1'b1);
    @(negedge CLK);
    t0 = cyc;
    bus_a.DIN = 8'h00;
    check_frame(0, 4, "ff", -1);
    push_frame(0, 8'h00, 1'b1);
    @(negedge CLK);
    t1 = cyc;
    bus_a.VALID = 1'b0;
    check("b2b period", t1 - t0, 32'd45);
    check_frame(0, 4, "00", -1);

    // Fast instance: no parity, one cycle per bit, DIN changed mid-frame.
    bus_b.DIN   = 8'h01;
    bus_b.VALID = 1'b1;
    push_frame(1, 8'h01, 1'b0);
    @(negedge CLK);
    bus_b.VALID = 1'b0;
    bus_b.DIN   = 8'hFE;
    check_frame(1, 1, "b01", -1);

    // VALID pulsed on the last busy cycle must be ignored.
    bus_a.DIN   = 8'hC3;
    bus_a.VALID = 1'b1;
    push_frame(0, 8'hC3, 1'b1);
    @(negedge CLK);
    bus_a.VALID = 1'b0;
    check_frame(0, 4, "busy_pulse", 43);
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      check_idle(0, "no_extra");
    end

    // Reset in the middle of data bit 3 of 8'h5A.
    bus_a.DIN   = 8'h5A;
    bus_a.VALID = 1'b1;
    @(negedge CLK);
    bus_a.VALID = 1'b0;
    repeat (17) @(negedge CLK);
    check("mid bit3 txd",   {31'd0, bus_a.TXD},   32'd1);
    check("mid bit3 ready", {31'd0, bus_a.READY}, 32'd0);
    RESET = 1'b1;
    #1;
    check_idle(0, "abort");
    @(negedge CLK);
    RESET       = 1'b0;
    bus_a.DIN   = 8'h3C;
    bus_a.VALID = 1'b1;
    push_frame(0, 8'h3C, 1'b1);
    @(negedge CLK);
    bus_a.VALID = 1'b0;
    check_frame(0, 4, "3c", -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-to-serial frame transmitter for the supergate benchmark set. It is the transmit end of the set's serial link: it accepts a word over a valid/ready handshake and shifts it out on one line as start bit, data LSB-first, optional even parity, and stop bit. It exercises the library's dff, imux2, xor2 and adder cells during mapping.

Parameters:
DATA_W, 8, data bits per frame (2..16)
CLKS_PER_BIT, 4, CLK cycles each serial bit is held (>=1)
PARITY_EN, 1, 1 = append even parity bit, 0 = no parity bit

Ports:
CLK  input  1  clock, rising-edge
RESET  input  1  asynchronous, active-high reset
DIN  input  DATA_W  word to transmit, sampled on accept
VALID  input  1  DIN valid
READY  output  1  transmitter idle, can accept
TXD  output  1  serial line, idles high
BUSY  output  1  frame in progress

Behaviour:
- Reset values (asynchronous, immediate): TXD=1, READY=1, BUSY=0, state=IDLE, all counters 0, shift register 0.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: VALID&&READY at a rising edge in IDLE. DIN is copied into the shift register. The parity bit (XOR of DIN) is registered. Next state is START.
- All outputs are registered. On the edge after accept: TXD=0, READY=0, BUSY=1.
- Bit timer counts 0..CLKS_PER_BIT-1. A bit ends at the edge where the count equals CLKS_PER_BIT-1. The timer then reloads to 0.
- START -> DATA.
- DATA: TXD = shreg[0]. At each bit end, shift right. The bit counter counts 0..DATA_W-1. After bit DATA_W-1 ends, go to PARITY if PARITY_EN, otherwise STOP.
- PARITY: TXD = registered parity. Go to STOP at bit end.
- STOP: TXD=1. At bit end, go to IDLE with READY=1 and BUSY=0.
- Frame length F = (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles of TXD activity.
- READY is low for exactly F cycles. The next accept can happen on the first IDLE edge, so back-to-back frame period is F+1 cycles.
- VALID while READY=0 is ignored. No acceptance, no queueing. Source must hold VALID.
- DIN changes after accept do not affect the frame in flight.
- CLKS_PER_BIT=1: each bit lasts one cycle, and the timer is a constant tick.
- Reset mid-frame: the line returns high immediately and the frame is abandoned. The first accept is possible on the first edge after RESET deasserts.
- Counter widths: $clog2 of the count range, minimum 1 bit. No wrap beyond the terminal count.

Decomposition:
- Package serial_link_pkg: state enum (IDLE, START, DATA, PARITY, STOP) and constant IDLE_LEVEL=1'b1.
- The package is shared with the future receiver.
- One sub-module, bit_timer: parameter CLKS_PER_BIT; ports CLK, RESET, EN, TICK.
- bit_timer is an async-reset counter. It asserts TICK on its terminal count and clears when EN=0.

Test Plan:
- Reset then idle, VALID=0 for 20 cycles -> TXD=1, READY=1, BUSY=0 throughout.
- Defaults, DIN=8'hA5, one-cycle VALID in IDLE:
  - TXD sequence is 0,1,0,1,0,0,1,0,1,0,1, each bit held 4 cycles (start, data LSB-first, parity 0, stop).
  - READY is low for 44 cycles and returns high on cycle 45.
- Back-to-back 8'hFF then 8'h00 with VALID held high:
  - Frames are 45 cycles apart.
  - Parity bits are 0 and 0.
  - The second accept occurs on the first READY-high edge.
- PARITY_EN=0, CLKS_PER_BIT=1, DIN=8'h01:
  - TXD is 0,1,0,0,0,0,0,0,0,1, a 10-cycle frame.
  - DIN toggled mid-frame leaves TXD unchanged.
- Assert RESET during data bit 3 of an 8'h5A frame -> TXD=1 and READY=1 within the same cycle. A new frame of 8'h3C after release transmits correctly.
- VALID pulsed while BUSY=1 -> ignored: no extra frame, and the current frame is unaffected.
